// File: rtl/instr_queue_decode.sv
// Instruction queue with full decode of the head entry.
// DEPTH-entry FIFO of {pc, word}, valid/ready on both sides, no bypass.
module instr_queue_decode #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned PC_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              read_data,
  input  logic [PC_W-1:0]          in_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PC_W-1:0]          out_pc,
  output logic [31:0]              instr,
  output logic [6:0]               opcode,
  output logic [4:0]               rd,
  output logic [2:0]               func3,
  output logic [4:0]               rs1,
  output logic [4:0]               rs2,
  output logic [6:0]               func7,
  output logic [31:0]              imm,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [31:0]     word;
  } entry_t;

  entry_t        mem_q [DEPTH];
  entry_t        head;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push;
  logic          pop;
  logic          sgn;

  assign in_ready  = (count_q != FULL);
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign count     = count_q;

  // flush drops everything; otherwise pointers and count follow push/pop
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      count_d  = '0;
      rd_ptr_d = wr_ptr_q;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // pointer and occupancy registers, synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // entry storage, written on an accepted push only
  always_ff @(posedge clk) begin
    if (rst_n && !flush && push) begin
      mem_q[wr_ptr_q] <= '{pc: in_pc, word: read_data};
    end
  end

  assign head   = mem_q[rd_ptr_q];
  assign out_pc = head.pc;
  assign instr  = head.word;
  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign func3  = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign func7  = instr[31:25];
  assign sgn    = instr[31];

  // immediate selected by instruction format
  always_comb begin
    imm = '0;
    unique case (opcode)
      OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM:
        imm = {{20{sgn}}, instr[31:20]};
      OP_STORE:
        imm = {{20{sgn}}, instr[31:25], instr[11:7]};
      OP_BRANCH:
        imm = {{20{sgn}}, instr[7], instr[30:25],
               instr[11:8], 1'b0};
      OP_LUI, OP_AUIPC:
        imm = {instr[31:12], 12'b0};
      OP_JAL:
        imm = {{12{sgn}}, instr[19:12], instr[20],
               instr[30:21], 1'b0};
      default:
        imm = '0;
    endcase
  end

endmodule

// File: tb/tb_instr_queue_decode.sv
// Bench for instr_queue_decode.
// Directed steps then random traffic against a queue-based model.
module tb_instr_queue_decode;

  localparam int DEPTH = 2;
  localparam int PC_W  = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] read_data;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [2:0]  func3;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [6:0]  func7;
  logic [31:0] imm;
  logic [1:0]  count;

  int checks = 0;
  int errors = 0;

  logic [31:0] qw [$];
  logic [31:0] qp [$];

  logic [6:0] ops [10] = '{7'h03, 7'h13, 7'h67, 7'h73,
                           7'h23, 7'h63, 7'h37, 7'h17,
                           7'h6F, 7'h33};

  instr_queue_decode #(
    .DEPTH(DEPTH),
    .PC_W (PC_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .read_data(read_data),
    .in_pc    (in_pc),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_pc   (out_pc),
    .instr    (instr),
    .opcode   (opcode),
    .rd       (rd),
    .func3    (func3),
    .rs1      (rs1),
    .rs2      (rs2),
    .func7    (func7),
    .imm      (imm),
    .count    (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sext(input logic [31:0] v,
                                       input int n);
    return v[n-1] ? v - (32'd1 << n) : v;
  endfunction

  function automatic logic [31:0] imm_ref(input logic [31:0] w);
    case (w[6:0])
      7'h03, 7'h13, 7'h67, 7'h73:
        return sext(32'(w[31:20]), 12);
      7'h23:
        return sext(32'({w[31:25], w[11:7]}), 12);
      7'h63:
        return sext(32'({w[31], w[7], w[30:25],
                         w[11:8], 1'b0}), 13);
      7'h37, 7'h17:
        return 32'(w[31:12]) << 12;
      7'h6F:
        return sext(32'({w[31], w[19:12], w[20],
                         w[30:21], 1'b0}), 21);
      default:
        return 32'd0;
    endcase
  endfunction

  task automatic check_state();
    logic [31:0] w;
    int n;
    n = qw.size();
    chk("count", 32'(count), 32'(n));
    chk("out_valid", 32'(out_valid), 32'(n != 0));
    chk("in_ready", 32'(in_ready), 32'(n != DEPTH));
    if (n != 0) begin
      w = qw[0];
      chk("out_pc", out_pc, qp[0]);
      chk("instr", instr, w);
      chk("opcode", 32'(opcode), 32'(w[6:0]));
      chk("rd", 32'(rd), 32'(w[11:7]));
      chk("func3", 32'(func3), 32'(w[14:12]));
      chk("rs1", 32'(rs1), 32'(w[19:15]));
      chk("rs2", 32'(rs2), 32'(w[24:20]));
      chk("func7", 32'(func7), 32'(w[31:25]));
      chk("imm", imm, imm_ref(w));
    end
  endtask

  task automatic cyc(input logic        iv,
                     input logic [31:0] w,
                     input logic [31:0] p,
                     input logic        ordy,
                     input logic        fl,
                     input logic        rn);
    bit push_e;
    bit pop_e;
    in_valid  = iv;
    read_data = w;
    in_pc     = p;
    out_ready = ordy;
    flush     = fl;
    rst_n     = rn;
    push_e = iv && (qw.size() < DEPTH);
    pop_e  = ordy && (qw.size() > 0);
    @(posedge clk);
    #1;
    if (!rn || fl) begin
      qw.delete();
      qp.delete();
    end else begin
      if (pop_e) begin
        void'(qw.pop_front());
        void'(qp.pop_front());
      end
      if (push_e) begin
        qw.push_back(w);
        qp.push_back(p);
      end
    end
    check_state();
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    w[6:0] = ops[$urandom_range(0, 9)];
    return w;
  endfunction

  initial begin
    in_valid  = 1'b0;
    read_data = '0;
    in_pc     = '0;
    out_ready = 1'b0;
    flush     = 1'b0;
    rst_n     = 1'b0;

    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    cyc(1, 32'hFFB10093, 32'h100, 0, 0, 1);
    chk("addi_rd", 32'(rd), 32'd1);
    chk("addi_rs1", 32'(rs1), 32'd2);
    chk("addi_op", 32'(opcode), 32'h13);
    chk("addi_imm", imm, 32'hFFFFFFFB);
    chk("addi_pc", out_pc, 32'h100);

    cyc(1, 32'h00512423, 32'h104, 1, 0, 1);
    chk("sw_rs2", 32'(rs2), 32'd5);
    chk("sw_f3", 32'(func3), 32'd2);
    chk("sw_imm", imm, 32'h8);

    cyc(1, 32'hFFDFF06F, 32'h108, 1, 0, 1);
    chk("jal_imm", imm, 32'hFFFFFFFC);

    cyc(0, 0, 0, 1, 0, 1);
    cyc(1, 32'h00100113, 32'h200, 0, 0, 1);
    cyc(1, 32'h00200193, 32'h204, 0, 0, 1);
    cyc(1, 32'h00300213, 32'h208, 0, 0, 1);
    chk("full_count", 32'(count), 32'd2);
    chk("full_rdy", 32'(in_ready), 32'd0);
    cyc(1, 32'h00400293, 32'h20C, 1, 0, 1);
    chk("full_pp", 32'(count), 32'd1);

    cyc(1, 32'h00500313, 32'h210, 1, 0, 1);
    chk("pp1_count", 32'(count), 32'd1);
    chk("pp1_head", instr, 32'h00500313);
    for (int i = 0; i < 8; i++)
      cyc(1, rand_word(), 32'h300 + 32'(i * 4), 1, 0, 1);

    cyc(1, rand_word(), 32'h400, 0, 0, 1);
    chk("pre_fl", 32'(count), 32'd2);
    cyc(1, rand_word(), 32'h404, 0, 1, 1);
    chk("fl_count", 32'(count), 32'd0);
    chk("fl_valid", 32'(out_valid), 32'd0);
    cyc(1, rand_word(), 32'h408, 0, 0, 1);
    cyc(1, rand_word(), 32'h40C, 1, 0, 0);
    chk("rst_mid", 32'(count), 32'd0);

    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(0, 3) != 0),
          rand_word(), $urandom,
          1'($urandom_range(0, 2) != 0),
          1'($urandom_range(0, 15) == 0),
          1'($urandom_range(0, 63) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
